// File: rtl/serial_pe_seq_if.sv
// Bundles the controller, neuron/weight buffer, PE and result buffer signals of serial_pe_seq.
// The slave modport is the sequencer's view; the master modport is the surrounding system's view.
interface serial_pe_seq_if #(
  parameter int LEN_W   = 8,
  parameter int OUT_W   = 8,
  parameter int WADDR_W = 16
);
  logic               start;
  logic [LEN_W-1:0]   vec_len;
  logic [OUT_W-1:0]   out_num;
  logic               busy;
  logic               done;
  logic               nrn_rd;
  logic [LEN_W-1:0]   nrn_addr;
  logic [15:0]        nrn_data;
  logic               wgt_rd;
  logic [WADDR_W-1:0] wgt_addr;
  logic [15:0]        wgt_data;
  logic [15:0]        pe_neuron;
  logic [15:0]        pe_weight;
  logic [1:0]         pe_ctl;
  logic               pe_vld;
  logic [31:0]        pe_result;
  logic               pe_vld_o;
  logic               res_we;
  logic [OUT_W-1:0]   res_addr;
  logic [31:0]        res_data;

  modport slave (
    input  start, vec_len, out_num, nrn_data, wgt_data, pe_result, pe_vld_o,
    output busy, done, nrn_rd, nrn_addr, wgt_rd, wgt_addr,
           pe_neuron, pe_weight, pe_ctl, pe_vld, res_we, res_addr, res_data
  );

  modport master (
    output start, vec_len, out_num, nrn_data, wgt_data, pe_result, pe_vld_o,
    input  busy, done, nrn_rd, nrn_addr, wgt_rd, wgt_addr,
           pe_neuron, pe_weight, pe_ctl, pe_vld, res_we, res_addr, res_data
  );
endinterface

// File: rtl/serial_pe_seq.sv
// Streams a neuron vector and out_num weight rows into one serial PE and writes each dot product out.
// Build macro SERIAL_PE_SEQ_RELU_EN clamps negative results to zero at write-back.
module serial_pe_seq #(
  parameter int LEN_W   = 8,
  parameter int OUT_W   = 8,
  parameter int WADDR_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_pe_seq_if.slave sif
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_FIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_k;
  logic [OUT_W-1:0]   r_out_num;
  logic [OUT_W-1:0]   r_o;
  logic [WADDR_W-1:0] r_wptr;
  logic               r_pe_vld;
  logic [1:0]         r_pe_ctl;
  logic               r_res_we;
  logic [OUT_W-1:0]   r_res_addr;
  logic [31:0]        r_res_data;
  logic               w_accept;
  logic               w_capture;
  logic               w_load;
  logic               w_k_last;
  logic               w_o_last;
  logic [31:0]        w_res_val;

  assign w_load   = (r_state == S_LOAD);
  assign w_k_last = (r_k == r_len - LEN_W'(1));
  assign w_o_last = (r_o == r_out_num - OUT_W'(1));

`ifdef SERIAL_PE_SEQ_RELU_EN
  assign w_res_val = sif.pe_result[31] ? 32'h0 : sif.pe_result;
`else
  assign w_res_val = sif.pe_result;
`endif

  // NOTE: state and counters are flops, so they take non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sif.start) begin
          w_accept    = 1'b1;
          w_state_nxt = (sif.vec_len == '0 || sif.out_num == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_k_last) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // After the last capture we linger one cycle so done trails the final res_we.
        if (r_res_we) begin
          w_state_nxt = S_FIN;
        end else if (sif.pe_vld_o) begin
          w_capture   = 1'b1;
          w_state_nxt = w_o_last ? S_WAIT : S_LOAD;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: only control/datapath flops are reset here; the buffers themselves live outside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_out_num  <= '0;
      r_k        <= '0;
      r_o        <= '0;
      r_wptr     <= '0;
      r_pe_vld   <= 1'b0;
      r_pe_ctl   <= 2'b00;
      r_res_we   <= 1'b0;
      r_res_addr <= '0;
      r_res_data <= '0;
    end else begin
      if (w_accept) begin
        r_len     <= sif.vec_len;
        r_out_num <= sif.out_num;
        r_k       <= '0;
        r_o       <= '0;
        r_wptr    <= '0;
      end else if (w_load) begin
        r_k    <= w_k_last ? '0 : r_k + LEN_W'(1);
        r_wptr <= r_wptr + WADDR_W'(1);
      end
      // PE framing is delayed one cycle so it coincides with the buffers' read data.
      r_pe_vld <= w_load;
      r_pe_ctl <= w_load ? {w_k_last, (r_k == '0)} : 2'b00;
      r_res_we <= w_capture;
      if (w_capture) begin
        r_res_addr <= r_o;
        r_res_data <= w_res_val;
        if (!w_o_last) r_o <= r_o + OUT_W'(1);
      end
    end
  end

  assign sif.busy      = (r_state != S_IDLE);
  assign sif.done      = (r_state == S_FIN);
  assign sif.nrn_rd    = w_load;
  assign sif.nrn_addr  = w_load ? r_k : '0;
  assign sif.wgt_rd    = w_load;
  assign sif.wgt_addr  = w_load ? r_wptr : '0;
  assign sif.pe_vld    = r_pe_vld;
  assign sif.pe_ctl    = r_pe_ctl;
  assign sif.pe_neuron = r_pe_vld ? sif.nrn_data : 16'h0;
  assign sif.pe_weight = r_pe_vld ? sif.wgt_data : 16'h0;
  assign sif.res_we    = r_res_we;
  assign sif.res_addr  = r_res_addr;
  assign sif.res_data  = r_res_data;
endmodule

// File: tb/tb_serial_pe_seq.sv
// Directed bench for serial_pe_seq: buffer and PE models, result scoreboard, timing checks.
// Expected results follow SERIAL_PE_SEQ_RELU_EN when it is defined.
module tb_serial_pe_seq;
  localparam int LEN_W   = 8;
  localparam int OUT_W   = 8;
  localparam int WADDR_W = 16;

  typedef struct {
    logic [OUT_W-1:0] addr;
    logic [31:0]      data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_pe_seq_if #(.LEN_W(LEN_W), .OUT_W(OUT_W), .WADDR_W(WADDR_W)) sif ();

  serial_pe_seq #(.LEN_W(LEN_W), .OUT_W(OUT_W), .WADDR_W(WADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sif  (sif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_cnt = 0;

  logic signed [15:0] nmem [256];
  logic signed [15:0] wmem [1024];
  logic [15:0] nrn_q    = '0;
  logic [15:0] wgt_q    = '0;
  logic [31:0] psum     = '0;
  logic [31:0] pe_res_q = '0;
  logic        pe_vo    = 1'b0;
  logic        inj      = 1'b0;

  exp_t             exp_q    [$];
  int               rd_cyc   [$];
  logic [15:0]      wa_log   [$];
  logic [LEN_W-1:0] na_log   [$];
  logic [1:0]       ctl_log  [$];
  int               res_cyc  [$];
  int               done_cyc [$];

  assign sif.nrn_data  = nrn_q;
  assign sif.wgt_data  = wgt_q;
  assign sif.pe_result = pe_res_q;
  assign sif.pe_vld_o  = pe_vo | inj;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef SERIAL_PE_SEQ_RELU_EN
    return x[31] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [31:0] mac(input logic [1:0] ctl, input logic [31:0] ps,
                                     input logic signed [15:0] n, input logic signed [15:0] w);
    logic signed [31:0] p;
    p = n * w;
    return (ctl[0] ? 32'h0 : ps) + p;
  endfunction

  // Single-port buffers with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sif.nrn_rd) nrn_q <= nmem[sif.nrn_addr];
    if (sif.wgt_rd) wgt_q <= wmem[sif.wgt_addr[9:0]];
  end

  // Serial PE: ctl[0] restarts the sum, ctl[1] publishes it with vld_o one cycle later.
  always @(posedge clk) begin
    pe_vo <= 1'b0;
    if (sif.pe_vld) begin
      psum <= mac(sif.pe_ctl, psum, sif.pe_neuron, sif.pe_weight);
      if (sif.pe_ctl[1]) begin
        pe_res_q <= mac(sif.pe_ctl, psum, sif.pe_neuron, sif.pe_weight);
        pe_vo    <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs_zero",
            32'(|{sif.busy, sif.done, sif.nrn_rd, sif.nrn_addr, sif.wgt_rd, sif.wgt_addr,
                  sif.pe_neuron, sif.pe_weight, sif.pe_ctl, sif.pe_vld,
                  sif.res_we, sif.res_addr, sif.res_data}), 32'h0);
    end else begin
      if (sif.busy) busy_cnt <= busy_cnt + 1;
      if (sif.nrn_rd) begin
        rd_cyc.push_back(cyc);
        wa_log.push_back(sif.wgt_addr);
        na_log.push_back(sif.nrn_addr);
      end
      if (sif.pe_vld) ctl_log.push_back(sif.pe_ctl);
      if (sif.done) done_cyc.push_back(cyc);
      if (sif.res_we) begin
        res_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("res_we_unexpected", 32'h1, 32'h0);
        end else begin
          check("res_addr", 32'(sif.res_addr), 32'(exp_q[0].addr));
          check("res_data", sif.res_data, exp_q[0].data);
          exp_q.delete(0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int a, input logic [31:0] d);
    exp_t e;
    e.addr = OUT_W'(a);
    e.data = relu(d);
    exp_q.push_back(e);
  endtask

  // Starts a batch; repulse > 0 re-asserts start that many cycles in with different fields.
  task automatic run_batch(input int len, input int num, input int repulse);
    int t;
    @(negedge clk);
    sif.start   = 1'b1;
    sif.vec_len = LEN_W'(len);
    sif.out_num = OUT_W'(num);
    @(negedge clk);
    sif.start = 1'b0;
    t = 0;
    while (!sif.done && t < 500) begin
      if (repulse > 0 && t == repulse) begin
        sif.start   = 1'b1;
        sif.vec_len = LEN_W'(1);
        sif.out_num = OUT_W'(1);
      end else begin
        sif.start = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    sif.start = 1'b0;
    check("done_within_budget", 32'(sif.done), 32'h1);
    repeat (4) @(negedge clk);
  endtask

  int rb, cb, sb, db, bb;
  task automatic snap();
    rb = rd_cyc.size();
    cb = ctl_log.size();
    sb = res_cyc.size();
    db = done_cyc.size();
    bb = busy_cnt;
  endtask

  task automatic load_two_output_vectors();
    for (int i = 0; i < 4; i++) nmem[i] = 16'(i + 1);
    wmem[0] = 16'sd1;  wmem[1] = 16'sd1; wmem[2] = 16'sd1;  wmem[3] = 16'sd1;
    wmem[4] = 16'sd2;  wmem[5] = 16'sd0; wmem[6] = -16'sd1; wmem[7] = 16'sd3;
  endtask

  task automatic check_two_output_batch(input string tag);
    check({tag, "_reads"}, 32'(rd_cyc.size() - rb), 32'd8);
    if (rd_cyc.size() >= rb + 8) begin
      for (int i = 0; i < 8; i++) begin
        check({tag, "_wgt_addr"}, 32'(wa_log[rb + i]), 32'(i));
        check({tag, "_nrn_addr"}, 32'(na_log[rb + i]), 32'(i % 4));
      end
    end
    check({tag, "_res_count"}, 32'(res_cyc.size() - sb), 32'd2);
    check({tag, "_done_count"}, 32'(done_cyc.size() - db), 32'd1);
    if (res_cyc.size() >= sb + 2 && rd_cyc.size() >= rb + 8 && done_cyc.size() > db) begin
      check({tag, "_lat0"}, 32'(res_cyc[sb] - rd_cyc[rb]), 32'd6);
      check({tag, "_lat1"}, 32'(res_cyc[sb + 1] - rd_cyc[rb + 4]), 32'd6);
      check({tag, "_done_after_we"}, 32'(done_cyc[db] - res_cyc[sb + 1]), 32'd1);
    end
    check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    sif.start   = 1'b0;
    sif.vec_len = '0;
    sif.out_num = '0;
    for (int i = 0; i < 256; i++)  nmem[i] = '0;
    for (int i = 0; i < 1024; i++) wmem[i] = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(sif.busy), 32'h0);
    check("idle_done", 32'(sif.done), 32'h0);

    // Two outputs of length 4.
    load_two_output_vectors();
    push_exp(0, 32'd10);
    push_exp(1, 32'd11);
    snap();
    run_batch(4, 2, 0);
    check_two_output_batch("two_out");

    // Length-1 vectors: every beat is both first and last.
    nmem[0] = 16'sd5;
    wmem[0] = 16'sd2; wmem[1] = -16'sd3; wmem[2] = 16'sd7;
    push_exp(0, 32'd10);
    push_exp(1, 32'hFFFF_FFF1);
    push_exp(2, 32'd35);
    snap();
    run_batch(1, 3, 0);
    check("len1_beats", 32'(ctl_log.size() - cb), 32'd3);
    if (ctl_log.size() >= cb + 3)
      for (int i = 0; i < 3; i++) check("len1_ctl", 32'(ctl_log[cb + i]), 32'd3);
    check("len1_res_count", 32'(res_cyc.size() - sb), 32'd3);
    if (res_cyc.size() >= sb + 3 && rd_cyc.size() >= rb + 3) begin
      check("len1_period_a", 32'(res_cyc[sb + 1] - res_cyc[sb]), 32'd3);
      check("len1_period_b", 32'(res_cyc[sb + 2] - res_cyc[sb + 1]), 32'd3);
      for (int i = 0; i < 3; i++) check("len1_wgt_addr", 32'(wa_log[rb + i]), 32'(i));
    end

    // Negative dot product.
    for (int i = 0; i < 4; i++) nmem[i] = 16'(i + 1);
    for (int i = 0; i < 4; i++) wmem[i] = -16'sd1;
`ifdef SERIAL_PE_SEQ_RELU_EN
    push_exp(0, 32'h0000_0000);
`else
    push_exp(0, 32'hFFFF_FFF6);
`endif
    snap();
    run_batch(4, 1, 0);
    check("neg_res_count", 32'(res_cyc.size() - sb), 32'd1);
    check("neg_ctl_first", (ctl_log.size() >= cb + 4) ? 32'(ctl_log[cb]) : 32'hDEAD, 32'd1);
    check("neg_ctl_last", (ctl_log.size() >= cb + 4) ? 32'(ctl_log[cb + 3]) : 32'hDEAD, 32'd2);

    // Zero length, then zero output count.
    for (int z = 0; z < 2; z++) begin
      snap();
      run_batch(z == 0 ? 0 : 2, z == 0 ? 3 : 0, 0);
      check("zero_busy_cycles", 32'(busy_cnt - bb), 32'd1);
      check("zero_done_count", 32'(done_cyc.size() - db), 32'd1);
      check("zero_reads", 32'(rd_cyc.size() - rb), 32'd0);
      check("zero_pe_vld", 32'(ctl_log.size() - cb), 32'd0);
      check("zero_res_we", 32'(res_cyc.size() - sb), 32'd0);
    end

    // A stray pe_vld_o in IDLE must not write a result.
    snap();
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_vld_o_res", 32'(res_cyc.size() - sb), 32'd0);
    check("stray_vld_o_busy", 32'(busy_cnt - bb), 32'd0);

    // start re-pulsed mid-batch is ignored.
    load_two_output_vectors();
    push_exp(0, 32'd10);
    push_exp(1, 32'd11);
    snap();
    run_batch(4, 2, 3);
    check_two_output_batch("repulse");

    // Reset in the middle of LOAD, then a fresh single output.
    load_two_output_vectors();
    @(negedge clk);
    sif.start   = 1'b1;
    sif.vec_len = LEN_W'(4);
    sif.out_num = OUT_W'(2);
    @(negedge clk);
    sif.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", 32'(sif.busy), 32'h0);
    nmem[0] = 16'sd1; nmem[1] = 16'sd2;
    wmem[0] = 16'sd3; wmem[1] = 16'sd4;
    push_exp(0, 32'd11);
    snap();
    run_batch(2, 1, 0);
    check("restart_res_count", 32'(res_cyc.size() - sb), 32'd1);
    check("restart_ctl_first", (ctl_log.size() >= cb + 2) ? 32'(ctl_log[cb]) : 32'hDEAD, 32'd1);
    check("restart_ctl_last", (ctl_log.size() >= cb + 2) ? 32'(ctl_log[cb + 1]) : 32'hDEAD, 32'd2);
    check("restart_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
